mem_bus_ctrl: RTL and testbench
===============================

Name: mem_bus_ctrl

Overview:
Memory bus sequencer between the CPU core and the ROM/RAM arrays. It accepts one read or write request at a time from the CPU and drives the registered 13-bit bus address into the address decoder. It samples the decoder's rom_sel/ram_sel, issues the matching memory strobe for a programmable number of wait states, and returns read data with a one-cycle ack. Write attempts to ROM and unmapped decodes complete with an error flag.

Parameters:
DW, 8, data bus width in bits.
ROM_WAIT, 2, extra ACCESS cycles for a ROM read (0..15).
RAM_WAIT, 1, extra ACCESS cycles for a RAM read or write (0..15).

Ports:
clk  in  1  system clock; all state changes on the rising edge.
rst  in  1  synchronous, active-high reset.
req  in  1  CPU request valid; sampled only in IDLE.
we  in  1  1 = write, 0 = read; qualified by req.
addr  in  13  CPU byte address; qualified by req.
wdata  in  DW  CPU write data; qualified by req.
busy  out  1  high in every state except IDLE.
ack  out  1  one-cycle completion pulse.
err  out  1  valid with ack; 1 = ROM write or no select.
rdata  out  DW  read data; valid with ack and held until the next read ack.
bus_addr  out  13  registered address driven to the decoder and memories.
rom_sel  in  1  from the address decoder.
ram_sel  in  1  from the address decoder.
rom_rd  out  1  ROM read strobe.
ram_rd  out  1  RAM read strobe.
ram_wr  out  1  RAM write strobe.
mem_wdata  out  DW  registered write data to RAM.
mem_rdata  in  DW  read data returned from the selected memory.

Behaviour:
- Reset values: state=IDLE, busy=0, ack=0, err=0, rdata=0, bus_addr=0, mem_wdata=0, all strobes 0, wait counter 0.
- FSM states: IDLE, DECODE, ACCESS, DONE.
- IDLE:
  - If req=1, latch addr into bus_addr, wdata into mem_wdata and we into an internal register; go to DECODE.
  - If req=0, stay in IDLE.
- DECODE (one cycle): bus_addr is stable and the decoder outputs are sampled into a target register.
  - rom_sel=1, ram_sel=0, read: target ROM; load counter with ROM_WAIT; go to ACCESS.
  - ram_sel=1, rom_sel=0: target RAM; load counter with RAM_WAIT; go to ACCESS.
  - rom_sel=1 with write, both selects 0, or both selects 1: set the error flag; go straight to DONE. No strobe is issued.
- ACCESS:
  - Exactly one strobe is high, chosen by target and latched we: rom_rd, ram_rd or ram_wr.
  - Strobes derive only from registered state, so they are glitch-free.
  - The counter decrements every cycle. When it is 0, capture mem_rdata into rdata (reads only) and go to DONE.
  - ACCESS therefore lasts WAIT+1 cycles.
- DONE (one cycle): ack=1, err=error flag, strobes 0; go to IDLE. The error flag clears on entry to IDLE.
- Latency: if req is accepted in cycle n, ack appears in cycle n+3+WAIT. The error path acks in cycle n+2.
- req is ignored while busy=1. No queuing. The CPU must hold req only until it sees busy.
- In IDLE, back-to-back requests are accepted the cycle after DONE.
- bus_addr and mem_wdata hold their values after DONE until the next accepted request.
- rdata updates only on a successful read; writes and errors leave it unchanged.
- Reset mid-operation (rst=1 in any state): return to IDLE next edge with all outputs at reset values. No ack is produced for the aborted access.
- Address map as produced by the decoder: 0x0000–0x17FF is ROM, 0x1800–0x1FFF is RAM. Boundary addresses 0x17FF and 0x1800 must route correctly.

Test Plan:
- ROM read addr=0x0100, mem_rdata=0xA5 -> rom_rd high for 3 cycles; ack in cycle n+5 with err=0 and rdata=0xA5; ram_rd and ram_wr never high.
- RAM write addr=0x1800, wdata=0x3C -> bus_addr=0x1800, mem_wdata=0x3C, ram_wr high for 2 cycles; ack in cycle n+4 with err=0; rdata unchanged.
- Write addr=0x17FF (ROM) -> no strobe; ack and err=1 in cycle n+2; then a RAM read of 0x1FFF returning 0x5A -> ack with err=0 and rdata=0x5A.
- Decoder forced to rom_sel=ram_sel=0 (and separately both 1) on a read -> no strobe; ack with err=1 in cycle n+2.
- req held high during a busy ROM read with addr changed to 0x1900 -> second request ignored until IDLE; bus_addr stays 0x0100 throughout the first access.
- rst pulsed during the second ACCESS cycle of a ROM read -> next cycle busy=0, rom_rd=0, rdata=0; no ack is ever seen for the aborted access.

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// mem_bus_ctrl
// Sequences one CPU read or write at a time onto the ROM/RAM bus.
// The request address is registered onto bus_addr. The external decoder's
// rom_sel/ram_sel are sampled one cycle later. The matching strobe is then held
// for WAIT+1 cycles, and the access completes with a one-cycle ack.
// A ROM write, or a decode with no select or both selects, completes with err.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   req/we/addr/wdata CPU request (sampled only while idle)
//   busy              high whenever a request is in progress
//   ack/err           completion pulse and its error qualifier
//   rdata             last successful read data
//   bus_addr          registered address to decoder and memories
//   rom_sel/ram_sel   decoder outputs
//   rom_rd/ram_rd/ram_wr  registered memory strobes
//   mem_wdata/mem_rdata   memory data paths
module mem_bus_ctrl #(
   parameter int DW       = 8,
   parameter int ROM_WAIT = 2,
   parameter int RAM_WAIT = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req,
   input  logic          we,
   input  logic [12:0]   addr,
   input  logic [DW-1:0] wdata,
   output logic          busy,
   output logic          ack,
   output logic          err,
   output logic [DW-1:0] rdata,
   output logic [12:0]   bus_addr,
   input  logic          rom_sel,
   input  logic          ram_sel,
   output logic          rom_rd,
   output logic          ram_rd,
   output logic          ram_wr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_DECODE = 2'd1;
   localparam logic [1:0] S_ACCESS = 2'd2;
   localparam logic [1:0] S_DONE   = 2'd3;

   logic [1:0] state;
   logic       we_q;
   logic       err_flag;
   logic [3:0] cnt;

   assign busy = (state != S_IDLE);
   // err is only meaningful alongside ack; both inputs are registers
   assign err  = ack & err_flag;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         we_q      <= 1'b0;
         err_flag  <= 1'b0;
         cnt       <= 4'd0;
         ack       <= 1'b0;
         rdata     <= '0;
         bus_addr  <= '0;
         mem_wdata <= '0;
         rom_rd    <= 1'b0;
         ram_rd    <= 1'b0;
         ram_wr    <= 1'b0;
      end else begin
         ack <= 1'b0;
         case (state)
            S_IDLE: begin
               if (req) begin
                  bus_addr  <= addr;
                  mem_wdata <= wdata;
                  we_q      <= we;
                  state     <= S_DECODE;
               end
            end

            // bus_addr has been stable for a full cycle, so the selects are settled
            S_DECODE: begin
               if (rom_sel && !ram_sel && !we_q) begin
                  cnt    <= 4'(ROM_WAIT);
                  rom_rd <= 1'b1;
                  state  <= S_ACCESS;
               end else if (ram_sel && !rom_sel) begin
                  cnt    <= 4'(RAM_WAIT);
                  ram_rd <= !we_q;
                  ram_wr <= we_q;
                  state  <= S_ACCESS;
               end else begin
                  // ROM write, unmapped or conflicting decode: skip the bus entirely
                  err_flag <= 1'b1;
                  ack      <= 1'b1;
                  state    <= S_DONE;
               end
            end

            // Strobes are registers, so they stay glitch-free for the whole access
            S_ACCESS: begin
               if (cnt == 4'd0) begin
                  if (!we_q) begin
                     rdata <= mem_rdata;
                  end
                  rom_rd <= 1'b0;
                  ram_rd <= 1'b0;
                  ram_wr <= 1'b0;
                  ack    <= 1'b1;
                  state  <= S_DONE;
               end else begin
                  cnt <= cnt - 4'd1;
               end
            end

            S_DONE: begin
               err_flag <= 1'b0;
               state    <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// tb_mem_bus_ctrl
// Scoreboard bench for mem_bus_ctrl: each request pushes its expected
// completion (latency, err, rdata, strobe cycle counts) and a negedge monitor
// pops and compares on every ack. The bench models the address decoder itself.
module tb_mem_bus_ctrl;

   localparam int DW       = 8;
   localparam int ROM_WAIT = 2;
   localparam int RAM_WAIT = 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          req = 1'b0;
   logic          we = 1'b0;
   logic [12:0]   addr = '0;
   logic [DW-1:0] wdata = '0;
   logic          busy, ack, err;
   logic [DW-1:0] rdata;
   logic [12:0]   bus_addr;
   logic          rom_sel, ram_sel;
   logic          rom_rd, ram_rd, ram_wr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;

   int dec_mode = 0;   // 0 normal map, 1 no select, 2 both selects
   int cyc = 0;
   int n_checks = 0;
   int n_errors = 0;
   logic [DW-1:0] m_rdata = '0;

   typedef struct {
      int         acc;
      int         lat;
      logic       err;
      logic [7:0] rd;
      int         nrom;
      int         nrd;
      int         nwr;
   } exp_t;
   exp_t sb_q[$];
   exp_t e_mon;
   int   c_rom = 0, c_rd = 0, c_wr = 0;

   mem_bus_ctrl #(.DW(DW), .ROM_WAIT(ROM_WAIT), .RAM_WAIT(RAM_WAIT)) dut (
      .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
      .busy(busy), .ack(ack), .err(err), .rdata(rdata), .bus_addr(bus_addr),
      .rom_sel(rom_sel), .ram_sel(ram_sel), .rom_rd(rom_rd), .ram_rd(ram_rd),
      .ram_wr(ram_wr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always_comb begin
      rom_sel = 1'b0;
      ram_sel = 1'b0;
      case (dec_mode)
         0: begin
            rom_sel = (bus_addr < 13'h1800);
            ram_sel = !(bus_addr < 13'h1800);
         end
         2: begin
            rom_sel = 1'b1;
            ram_sel = 1'b1;
         end
         default: ;
      endcase
   end

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (!rst) begin
         if (rom_rd) c_rom++;
         if (ram_rd) c_rd++;
         if (ram_wr) c_wr++;
         if (rom_rd | ram_rd | ram_wr)
            check_eq("strobe_onehot", 32'(rom_rd) + 32'(ram_rd) + 32'(ram_wr), 1);
         if (ack) begin
            if (sb_q.size() == 0) begin
               check_eq("spurious_ack", 32'(ack), 0);
            end else begin
               e_mon = sb_q.pop_front();
               check_eq("ack_latency", cyc - e_mon.acc, e_mon.lat);
               check_eq("ack_err", 32'(err), 32'(e_mon.err));
               check_eq("ack_rdata", 32'(rdata), 32'(e_mon.rd));
               check_eq("rom_rd_cycles", c_rom, e_mon.nrom);
               check_eq("ram_rd_cycles", c_rd, e_mon.nrd);
               check_eq("ram_wr_cycles", c_wr, e_mon.nwr);
            end
         end
         if (!busy) begin
            c_rom = 0;
            c_rd  = 0;
            c_wr  = 0;
         end
      end
   end

   // Expected completion from the address map, wait states and decoder mode
   function automatic exp_t model(input logic w, input logic [12:0] a, input int acc);
      exp_t e;
      logic is_rom;
      is_rom = (a < 13'h1800);
      e.acc  = acc;
      e.err  = (dec_mode != 0) || (is_rom && w);
      e.lat  = e.err ? 1 : 2 + (is_rom ? ROM_WAIT : RAM_WAIT);
      e.nrom = (!e.err && is_rom) ? ROM_WAIT + 1 : 0;
      e.nrd  = (!e.err && !is_rom && !w) ? RAM_WAIT + 1 : 0;
      e.nwr  = (!e.err && !is_rom && w) ? RAM_WAIT + 1 : 0;
      if (!e.err && !w) m_rdata = mem_rdata;
      e.rd   = m_rdata;
      return e;
   endfunction

   task automatic wait_idle();
      for (int i = 0; i < 40; i++) begin
         if (!busy) break;
         @(posedge clk); #1;
      end
      check_eq("idle_timeout", 32'(busy), 0);
   endtask

   task automatic do_req(input logic w, input logic [12:0] a, input logic [DW-1:0] d);
      req = 1'b1; we = w; addr = a; wdata = d;
      @(posedge clk); #1;
      sb_q.push_back(model(w, a, cyc));
      check_eq("accept_busy", 32'(busy), 1);
      check_eq("accept_bus_addr", 32'(bus_addr), 32'(a));
      check_eq("accept_mem_wdata", 32'(mem_wdata), 32'(d));
      req = 1'b0;
      wait_idle();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, errors=%0d", n_errors);
      $fatal(1);
   end

   initial begin
      int acks;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_busy", 32'(busy), 0);
      check_eq("rst_ack", 32'(ack), 0);
      check_eq("rst_err", 32'(err), 0);
      check_eq("rst_rdata", 32'(rdata), 0);
      check_eq("rst_bus_addr", 32'(bus_addr), 0);
      check_eq("rst_mem_wdata", 32'(mem_wdata), 0);
      check_eq("rst_strobes", {29'd0, rom_rd, ram_rd, ram_wr}, 0);
      rst = 1'b0;
      @(posedge clk); #1;

      // ROM read
      mem_rdata = 8'hA5;
      do_req(1'b0, 13'h0100, 8'h00);
      check_eq("rom_read_rdata", 32'(rdata), 32'hA5);

      // RAM write at the lowest RAM address
      do_req(1'b1, 13'h1800, 8'h3C);
      check_eq("ram_write_bus_addr", 32'(bus_addr), 32'h1800);
      check_eq("ram_write_mem_wdata", 32'(mem_wdata), 32'h3C);
      check_eq("ram_write_rdata_kept", 32'(rdata), 32'hA5);

      // ROM write at the highest ROM address, then RAM read at the top
      do_req(1'b1, 13'h17FF, 8'h99);
      check_eq("rom_write_rdata_kept", 32'(rdata), 32'hA5);
      mem_rdata = 8'h5A;
      do_req(1'b0, 13'h1FFF, 8'h00);
      check_eq("ram_read_rdata", 32'(rdata), 32'h5A);

      // Broken decodes on reads
      dec_mode = 1;
      do_req(1'b0, 13'h0200, 8'h00);
      dec_mode = 2;
      do_req(1'b0, 13'h1A00, 8'h00);
      dec_mode = 0;
      check_eq("bad_decode_rdata_kept", 32'(rdata), 32'h5A);

      // req held high through a busy ROM read with the address changed
      mem_rdata = 8'h77;
      req = 1'b1; we = 1'b0; addr = 13'h0100; wdata = 8'h00;
      @(posedge clk); #1;
      sb_q.push_back(model(1'b0, 13'h0100, cyc));
      addr = 13'h1900;
      for (int i = 0; i < 20; i++) begin
         check_eq("hold_bus_addr", 32'(bus_addr), 32'h0100);
         if (ack) break;
         @(posedge clk); #1;
      end
      check_eq("hold_ack_seen", 32'(ack), 1);
      req = 1'b0;
      @(posedge clk); #1;
      check_eq("hold_idle", 32'(busy), 0);
      check_eq("hold_bus_addr_after", 32'(bus_addr), 32'h0100);
      @(posedge clk); #1;
      check_eq("hold_no_second", 32'(busy), 0);

      // Back-to-back random traffic around the map
      for (int i = 0; i < 12; i++) begin
         mem_rdata = 8'($urandom);
         do_req(1'($urandom_range(1)), 13'($urandom_range(13'h1700, 13'h18FF)), 8'($urandom));
      end

      // Reset during the second ACCESS cycle of a ROM read
      mem_rdata = 8'h11;
      req = 1'b1; we = 1'b0; addr = 13'h0300; wdata = 8'h00;
      @(posedge clk); #1;
      req = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      check_eq("abort_pre_rom_rd", 32'(rom_rd), 1);
      rst = 1'b1;
      @(posedge clk); #1;
      check_eq("abort_busy", 32'(busy), 0);
      check_eq("abort_rom_rd", 32'(rom_rd), 0);
      check_eq("abort_rdata", 32'(rdata), 0);
      check_eq("abort_bus_addr", 32'(bus_addr), 0);
      rst = 1'b0;
      m_rdata = '0;
      acks = 0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (ack) acks++;
      end
      check_eq("abort_no_ack", acks, 0);

      // Normal operation after the abort
      mem_rdata = 8'hC3;
      do_req(1'b0, 13'h0000, 8'h00);
      check_eq("post_abort_rdata", 32'(rdata), 32'hC3);

      check_eq("queue_drained", sb_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
